// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequencer for the custom-instruction FFT unit (load, radix-2 compute, export)
// Ports:
//    clk, rst             clock, asynchronous active-high reset
//    cmd_valid/op/data    FFT command held in EX (01 LOAD, 10 CAL, 11 EXPORT)
//    stall                freezes IF/ID/EX while a CAL or EXPORT is in progress
//    buf_we/waddr/wdata   sample buffer write port (LOAD)
//    buf_re/raddr/rdata   result buffer read port, rdata valid one cycle after re
//    bf_issue/stage/idx   butterfly engine issue interface
//    exp_valid/exp_data   exported result writeback
//    done, err            CAL completion pulse, sticky illegal-sequence flag
// Build option: define FFT_BITREV_EN to write samples in bit-reversed address order.
module fft_seq_ctrl #(
   parameter int LOG2N  = 3,
   parameter int BF_LAT = 2,
   parameter int XLEN   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [XLEN-1:0]  cmd_data,
   output logic             stall,
   output logic             buf_we,
   output logic [LOG2N-1:0] buf_waddr,
   output logic [XLEN-1:0]  buf_wdata,
   output logic             buf_re,
   output logic [LOG2N-1:0] buf_raddr,
   input  logic [XLEN-1:0]  buf_rdata,
   output logic             bf_issue,
   output logic [3:0]       bf_stage,
   output logic [LOG2N-2:0] bf_idx,
   output logic             exp_valid,
   output logic [XLEN-1:0]  exp_data,
   output logic             done,
   output logic             err
);
   localparam int HALF = (1 << LOG2N) / 2;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, EXP_RSP} state_t;
   state_t           state_q, state_d;
   logic [LOG2N-1:0] ld_ptr_q, ld_ptr_d, ex_ptr_q, ex_ptr_d, ld_addr;
   logic             ld_full_q, ld_full_d, res_rdy_q, res_rdy_d;
   logic             err_q, err_d, bad_q, bad_d;
   logic [3:0]       stage_q, stage_d, cnt_q, cnt_d;
   logic [LOG2N-2:0] idx_q, idx_d;
   logic             accept, is_ld, is_cal, is_exp, last_idx, last_stage, busy;
`ifdef FFT_BITREV_EN
   function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] a);
      for (int i = 0; i < LOG2N; i++) rev[i] = a[LOG2N-1-i];
   endfunction
   assign ld_addr = rev(ld_ptr_q);
`else
   assign ld_addr = ld_ptr_q;
`endif
   // rst gates the combinational accept so every output reads 0 while reset is held
   assign accept     = cmd_valid && state_q == IDLE && !rst;
   assign is_ld      = accept && cmd_op == 2'b01;
   assign is_cal     = accept && cmd_op == 2'b10;
   assign is_exp     = accept && cmd_op == 2'b11;
   assign last_idx   = idx_q == (LOG2N-1)'(HALF - 1);
   assign last_stage = stage_q == 4'(LOG2N - 1);
   assign busy       = state_q == RUN || state_q == DRAIN;
   assign stall      = (is_cal && ld_full_q) || is_exp || busy;
   assign buf_we     = is_ld;
   assign buf_waddr  = is_ld ? ld_addr : '0;
   assign buf_wdata  = is_ld ? cmd_data : '0;
   assign buf_re     = is_exp;
   assign buf_raddr  = is_exp ? ex_ptr_q : '0;
   assign bf_issue   = state_q == RUN;
   assign bf_stage   = busy ? stage_q : '0;
   assign bf_idx     = busy ? idx_q : '0;
   assign exp_valid  = state_q == EXP_RSP;
   assign exp_data   = (state_q == EXP_RSP && !bad_q) ? buf_rdata : '0;
   assign done       = state_q == DONE;
   assign err        = err_q;
   always_comb begin
      state_d   = state_q;
      ld_ptr_d  = ld_ptr_q;
      ex_ptr_d  = ex_ptr_q;
      ld_full_d = ld_full_q;
      res_rdy_d = res_rdy_q;
      err_d     = err_q;
      bad_d     = bad_q;
      stage_d   = stage_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      case (state_q)
         IDLE: begin
            if (is_ld) begin
               ld_ptr_d  = ld_ptr_q + 1'b1;
               ld_full_d = ld_full_q || ld_ptr_q == '1;
            end
            if (is_cal && !ld_full_q) err_d = 1'b1;
            if (is_cal && ld_full_q) begin
               state_d = RUN;
               stage_d = '0;
               idx_d   = '0;
            end
            if (is_exp) begin
               state_d = EXP_RSP;
               bad_d   = !res_rdy_q;
               err_d   = err_q || !res_rdy_q;
            end
         end
         RUN: begin
            idx_d = idx_q + 1'b1;
            // The DONE cycle is itself the last idle cycle after the final stage,
            // so the final drain is one cycle shorter (skipped entirely when BF_LAT=1).
            if (last_idx) begin
               state_d = (last_stage && BF_LAT == 1) ? DONE : DRAIN;
               cnt_d   = last_stage ? 4'd1 : 4'd0;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == 4'(BF_LAT - 1)) begin
               state_d = last_stage ? DONE : RUN;
               stage_d = last_stage ? stage_q : stage_q + 1'b1;
            end
         end
         DONE: begin
            state_d   = IDLE;
            ld_ptr_d  = '0;
            ld_full_d = 1'b0;
            res_rdy_d = 1'b1;
            ex_ptr_d  = '0;
         end
         EXP_RSP: begin
            state_d = IDLE;
            if (!bad_q) begin
               ex_ptr_d  = ex_ptr_q + 1'b1;
               res_rdy_d = ex_ptr_q != '1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ld_ptr_q  <= '0;
         ex_ptr_q  <= '0;
         ld_full_q <= 1'b0;
         res_rdy_q <= 1'b0;
         err_q     <= 1'b0;
         bad_q     <= 1'b0;
         stage_q   <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         ld_ptr_q  <= ld_ptr_d;
         ex_ptr_q  <= ex_ptr_d;
         ld_full_q <= ld_full_d;
         res_rdy_q <= res_rdy_d;
         err_q     <= err_d;
         bad_q     <= bad_d;
         stage_q   <= stage_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: scoreboard bench for fft_seq_ctrl (N=8, BF_LAT=2)
module tb_fft_seq_ctrl;
   localparam int LOG2N = 3;
   localparam int BF_LAT = 2;
   localparam int XLEN = 32;
   logic            clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
   logic [1:0]      cmd_op = 2'b00;
   logic [XLEN-1:0] cmd_data = '0, buf_rdata = '0;
   logic            stall, buf_we, buf_re, bf_issue, exp_valid, done, err;
   logic [LOG2N-1:0] buf_waddr, buf_raddr;
   logic [XLEN-1:0] buf_wdata, exp_data;
   logic [3:0]      bf_stage;
   logic [LOG2N-2:0] bf_idx;
   int total = 0, bad = 0, ex_cnt = 0;
   logic [XLEN-1:0]  sb_q[$];
   logic [LOG2N-1:0] addr_q[$];
   fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .stall(stall), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
      .bf_issue(bf_issue), .bf_stage(bf_stage), .bf_idx(bf_idx),
      .exp_valid(exp_valid), .exp_data(exp_data), .done(done), .err(err));
   always #5 clk = ~clk;
   always @(posedge clk) if (buf_re) buf_rdata <= 32'h100 + 32'(buf_raddr);
   function automatic logic [LOG2N-1:0] ea(input int i);
`ifdef FFT_BITREV_EN
      logic [LOG2N-1:0] t [8];
      t = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      return t[i % 8];
`else
      return 3'(i % 8);
`endif
   endfunction
   function automatic logic any_out();
      return |{stall, buf_we, buf_waddr, buf_wdata, buf_re, buf_raddr, bf_issue,
               bf_stage, bf_idx, exp_valid, exp_data, done, err};
   endfunction
   task automatic next();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] d);
      cmd_valid = v;
      cmd_op = op;
      cmd_data = d;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 2'b00, '0);
      next();
      rst = 1'b0;
      next();
   endtask
   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 2'b01, 32'hdead);
      @(negedge clk);
      total++;
      if (any_out() !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got nonzero output, want all 0");
      end
      next();
      rst = 1'b0;
      drive(1'b0, 2'b00, '0);
      next();
   endtask
   task automatic test_load(input int n, input logic [XLEN-1:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 2'b01, base + XLEN'(i));
         addr_q.push_back(ea(i));
         sb_q.push_back(base + XLEN'(i));
         @(negedge clk);
         total++;
         if (stall !== 1'b0 || buf_we !== 1'b1) begin
            bad++;
            $display("FAIL load_we: got stall=%b we=%b want stall=0 we=1", stall, buf_we);
         end
         begin
            logic [LOG2N-1:0] a;
            logic [XLEN-1:0] d;
            a = addr_q.pop_front();
            d = sb_q.pop_front();
            total++;
            if (buf_waddr !== a || buf_wdata !== d) begin
               bad++;
               $display("FAIL load_write: got addr=%0d data=%0h want addr=%0d data=%0h", buf_waddr, buf_wdata, a, d);
            end
         end
         next();
      end
      drive(1'b0, 2'b00, '0);
   endtask
   task automatic test_cal(input bit poke_load);
      int stall_n, done_at;
      int iss [3];
      stall_n = 0;
      done_at = -1;
      iss = '{0, 0, 0};
      drive(1'b1, 2'b10, '0);
      for (int c = 0; c < 60 && done_at < 0; c++) begin
         if (poke_load && c >= 1) drive(1'b1, 2'b01, 32'hbad);
         @(negedge clk);
         if (stall) stall_n++;
         if (poke_load && c >= 1) begin
            total++;
            if (buf_we !== 1'b0) begin
               bad++;
               $display("FAIL load_in_stall: got we=%b want 0 (cycle %0d)", buf_we, c);
            end
         end
         if (bf_issue) begin
            total++;
            if (bf_stage > 4'd2 || bf_idx !== 2'(iss[bf_stage % 3])) begin
               bad++;
               $display("FAIL bf_issue_seq: got stage=%0d idx=%0d cycle=%0d", bf_stage, bf_idx, c);
            end else iss[bf_stage]++;
         end
         if (done) begin
            done_at = c;
            total++;
            if (stall !== 1'b0) begin
               bad++;
               $display("FAIL done_stall: got %b want 0", stall);
            end
         end
         next();
      end
      drive(1'b0, 2'b00, '0);
      total++;
      if (done_at !== 18) begin
         bad++;
         $display("FAIL cal_done_cycle: got %0d want 18", done_at);
      end
      total++;
      if (stall_n !== 18) begin
         bad++;
         $display("FAIL cal_stall_cycles: got %0d want 18", stall_n);
      end
      total++;
      if (iss[0] !== 4 || iss[1] !== 4 || iss[2] !== 4) begin
         bad++;
         $display("FAIL cal_issue_count: got %0d/%0d/%0d want 4/4/4", iss[0], iss[1], iss[2]);
      end
      @(negedge clk);
      total++;
      if (stall !== 1'b0 || bf_issue !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL cal_in_done_ignored: got stall=%b issue=%b err=%b want 0/0/0", stall, bf_issue, err);
      end
      next();
      ex_cnt = 0;
   endtask
   task automatic test_export(input int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, 2'b11, '0);
         sb_q.push_back(ex_cnt < 8 ? 32'h100 + XLEN'(ex_cnt) : '0);
         @(negedge clk);
         total++;
         if (stall !== 1'b1 || buf_re !== 1'b1 || exp_valid !== 1'b0) begin
            bad++;
            $display("FAIL export_req: got stall=%b re=%b ev=%b want 1/1/0", stall, buf_re, exp_valid);
         end
         next();
         drive(1'b0, 2'b00, '0);
         @(negedge clk);
         begin
            logic [XLEN-1:0] want;
            want = sb_q.pop_front();
            total++;
            if (stall !== 1'b0 || exp_valid !== 1'b1 || exp_data !== want) begin
               bad++;
               $display("FAIL export_rsp: got stall=%b ev=%b data=%0h want 0/1/%0h", stall, exp_valid, exp_data, want);
            end
         end
         next();
         ex_cnt++;
         if (ex_cnt == 8) begin
            total++;
            if (err !== 1'b0) begin
               bad++;
               $display("FAIL export_err_early: got %b want 0", err);
            end
         end
      end
      if (ex_cnt > 8) begin
         total++;
         if (err !== 1'b1) begin
            bad++;
            $display("FAIL export_empty_err: got %b want 1", err);
         end
      end
   endtask
   task automatic test_cal_short();
      do_reset();
      test_load(5, 32'h40);
      drive(1'b1, 2'b10, '0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (stall !== 1'b0 || bf_issue !== 1'b0) begin
            bad++;
            $display("FAIL short_cal_run: got stall=%b issue=%b want 0/0", stall, bf_issue);
         end
         next();
         drive(1'b0, 2'b00, '0);
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL short_cal_err: got %b want 1", err);
      end
   endtask
   task automatic test_reset_mid_run();
      bit hit;
      do_reset();
      test_load(8, 32'h1);
      drive(1'b1, 2'b10, '0);
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (bf_stage == 4'd1) hit = 1'b1;
         else next();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_run_timeout: got no stage 1 want stage 1 within 40 cycles");
      end
      rst = 1'b1;
      #1;
      total++;
      if (any_out() !== 1'b0) begin
         bad++;
         $display("FAIL mid_run_reset: got nonzero output want all 0");
      end
      drive(1'b0, 2'b00, '0);
      next();
      rst = 1'b0;
      next();
      drive(1'b1, 2'b10, '0);
      @(negedge clk);
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_cal_stall: got %b want 0", stall);
      end
      next();
      drive(1'b0, 2'b00, '0);
      @(negedge clk);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_cal_err: got %b want 1", err);
      end
      next();
   endtask
   task automatic test_back_to_back();
      do_reset();
      test_load(11, 32'h10);
      test_cal(1'b1);
      test_load(1, 32'h55);
      test_export(2);
   endtask
   initial begin
      test_reset();
      test_load(8, 32'h1);
      test_cal(1'b0);
      test_export(9);
      test_cal_short();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
